// File: rtl/data_mem_store_buffer.sv
// Data memory with a 4-entry store buffer: stores are queued and drained into a
// 64-word RAM whenever the port is free; loads forward from the youngest match.
module data_mem_store_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUout,
  input  logic [31:0] writedata,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] readdata,
  output logic        stall,
  output logic [2:0]  buf_count
);

  localparam int unsigned DW        = 32;
  localparam int unsigned IW        = 6;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned PW        = 2;
  localparam int unsigned CW        = 3;
  localparam int unsigned RAM_WORDS = 64;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } sb_entry_t;

  sb_entry_t       r_buf [DEPTH];
  logic [DW-1:0]   r_ram [RAM_WORDS];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [DW-1:0]   r_readdata;

  logic [IW-1:0]   w_idx;
  logic            w_full;
  logic            w_accept;
  logic            w_drain;
  logic            w_load;
  logic [CW-1:0]   w_count_nxt;
  sb_entry_t       w_ord [DEPTH];
  logic            w_fwd_hit;
  logic [DW-1:0]   w_fwd_data;
  logic [DW-1:0]   w_load_data;
  sb_entry_t       w_head_entry;
  logic            w_unused_addr_bits;

  assign w_idx              = ALUout[7:2];
  assign w_unused_addr_bits = ^{ALUout[31:8], ALUout[1:0]};

  // Full buffer stalls a store even if the head drains this same cycle.
  assign w_full   = (r_count == CW'(DEPTH));
  assign stall    = MemWrite & w_full;
  assign w_accept = MemWrite & ~w_full;
  assign w_drain  = (r_count != CW'(0)) & ~MemRead;
  assign w_load   = MemRead & ~MemWrite;

  assign w_head_entry = r_buf[r_head];

  always_comb begin
    w_count_nxt = r_count;
    case ({w_accept, w_drain})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Entries in age order: w_ord[0] is the oldest (head).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_ord[i] = r_buf[r_head + PW'(i)];
    end
  end

  // Later (younger) matches overwrite earlier ones, so the youngest wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) && (w_ord[i].idx == w_idx)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = w_ord[i].data;
      end
    end
  end

  assign w_load_data = w_fwd_hit ? w_fwd_data : r_ram[w_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_readdata <= '0;
    end else begin
      if (w_accept) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_drain) begin
        r_head <= r_head + PW'(1);
      end
      r_count <= w_count_nxt;
      if (w_load) begin
        r_readdata <= w_load_data;
      end
    end
  end

  // Buffer payload needs no reset; validity is carried by the pointers and count.
  always_ff @(posedge clk) begin
    if (!reset && w_accept) begin
      r_buf[r_tail].idx  <= w_idx;
      r_buf[r_tail].data <= writedata;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && w_drain) begin
      r_ram[w_head_entry.idx] <= w_head_entry.data;
    end
  end

  assign readdata  = r_readdata;
  assign buf_count = r_count;

endmodule

// File: tb/tb_data_mem_store_buffer.sv
// Randomized and directed bench for data_mem_store_buffer against a queue-based
// model of the store buffer and an array model of the RAM.
module tb_data_mem_store_buffer;

  logic        clk;
  logic        reset;
  logic [31:0] ALUout;
  logic [31:0] writedata;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] readdata;
  logic        stall;
  logic [2:0]  buf_count;

  data_mem_store_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .ALUout    (ALUout),
    .writedata (writedata),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .readdata  (readdata),
    .stall     (stall),
    .buf_count (buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_ram[64];
  logic [31:0] m_rd;
  int          n_cmp;
  int          n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle, check stall before the edge, update the model at the edge,
  // then check registered outputs.
  task automatic step(input bit rst, input bit we, input bit rd,
                      input logic [31:0] addr, input logic [31:0] wd);
    logic [5:0] idx;
    bit         found;
    bit         acc;
    bit         dr;
    reset     = rst;
    MemWrite  = we;
    MemRead   = rd;
    ALUout    = addr;
    writedata = wd;
    #1;
    check("stall", 32'(stall), 32'(we && (m_q.size() == 4)));
    @(posedge clk);
    idx = addr[7:2];
    if (rst) begin
      m_q.delete();
      m_rd = '0;
    end else begin
      if (rd && !we) begin
        found = 1'b0;
        for (int i = m_q.size() - 1; i >= 0; i--) begin
          if (!found && m_q[i].idx == idx) begin
            m_rd  = m_q[i].data;
            found = 1'b1;
          end
        end
        if (!found) m_rd = m_ram[idx];
      end
      acc = we && (m_q.size() < 4);
      dr  = (m_q.size() > 0) && !rd;
      if (dr) begin
        m_ram[m_q[0].idx] = m_q[0].data;
        void'(m_q.pop_front());
      end
      if (acc) m_q.push_back('{idx, wd});
    end
    #1;
    check("buf_count", 32'(buf_count), 32'(m_q.size()));
    check("readdata", readdata, m_rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  logic [31:0] saved [3];
  logic [31:0] a;

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_rd  = '0;
    for (int i = 0; i < 64; i++) m_ram[i] = 'x;
    reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; ALUout = '0; writedata = '0;

    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    check("reset_count", 32'(buf_count), 32'd0);
    check("reset_readdata", readdata, 32'd0);

    // Preload every RAM word through the buffer, storing and draining each cycle.
    for (int i = 0; i < 64; i++) begin
      a = $urandom;
      a[7:2] = 6'(i);
      step(1'b0, 1'b1, 1'b0, a, $urandom);
    end
    idle(5);

    // Store, drain over idle cycles, then load it back.
    step(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    check("r029_cnt1", 32'(buf_count), 32'd1);
    idle(2);
    check("r029_cnt0", 32'(buf_count), 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h10, 32'h0);
    check("r029_load", readdata, 32'hDEADBEEF);

    // Two stores to the same word with no drain; load forwards the youngest.
    step(1'b0, 1'b1, 1'b1, 32'h20, 32'h11111111);
    step(1'b0, 1'b1, 1'b1, 32'h20, 32'h22222222);
    step(1'b0, 1'b0, 1'b1, 32'h20, 32'h0);
    check("r030_fwd", readdata, 32'h22222222);
    idle(3);
    step(1'b0, 1'b0, 1'b1, 32'h20, 32'h0);
    check("r030_ram", readdata, 32'h22222222);

    // Fill to four with MemRead held; the fifth stalls until space frees.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 32'(i * 4 + 32'h80), 32'hA000_0000 + 32'(i));
    check("r031_full", 32'(buf_count), 32'd4);
    step(1'b0, 1'b1, 1'b0, 32'h90, 32'hA000_0004);
    step(1'b0, 1'b1, 1'b0, 32'h90, 32'hA000_0004);
    idle(5);
    step(1'b0, 1'b0, 1'b1, 32'h90, 32'h0);
    check("r031_fifth", readdata, 32'hA000_0004);

    // Load a non-buffered word while other indices are pending; readdata holds.
    step(1'b0, 1'b1, 1'b1, 32'h44, 32'h5555_0001);
    step(1'b0, 1'b1, 1'b1, 32'h48, 32'h5555_0002);
    step(1'b0, 1'b0, 1'b1, 32'h40, 32'h0);
    check("r032_ram", readdata, m_ram[16]);
    idle(3);
    check("r032_hold", readdata, m_ram[16]);

    // Reset with pending stores discards them; RAM keeps old values.
    for (int i = 0; i < 3; i++) saved[i] = m_ram[8'hC0 / 4 + i];
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 32'hC0 + 32'(4 * i), 32'hBAD0_0000 + 32'(i));
    step(1'b1, 1'b1, 1'b0, 32'hC0, 32'hFFFF_FFFF);
    check("r033_count", 32'(buf_count), 32'd0);
    check("r033_rd", readdata, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'hC0 + 32'(4 * i), 32'h0);
      check("r033_old", readdata, saved[i]);
    end

    // Tail to 3, then six store+drain cycles across the pointer wrap.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 32'(4 * (40 + i)), 32'hC0DE_0000 + 32'(i));
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'(4 * (43 + i)), 32'hC0DE_0003 + 32'(i));
      check("r034_count", 32'(buf_count), 32'd3);
    end
    idle(4);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'(4 * (40 + i)), 32'h0);
      check("r034_ram", readdata, 32'hC0DE_0000 + 32'(i));
    end

    // Random traffic over a small index range to exercise forwarding.
    for (int n = 0; n < 3000; n++) begin
      bit rst;
      bit we;
      bit rd;
      rst = ($urandom_range(0, 99) == 0);
      we  = $urandom_range(0, 1) == 1;
      rd  = ($urandom_range(0, 2) == 0);
      a = $urandom;
      a[7:2] = 6'($urandom_range(0, 7));
      step(rst, we, rd, a, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_store_buffer.md
DATA_MEM_STORE_BUFFER -- requirements
Module: data_mem_store_buffer

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-002 clk  input  1  Core clock; all state updates on the rising edge.
REQ-003 reset  input  1  Synchronous, active-high reset.
REQ-004 ALUout  input  32  Byte address from the ALU; word index = ALUout[7:2]; bits [1:0] and [31:8] ignored.
REQ-005 writedata  input  32  Store data.
REQ-006 MemWrite  input  1  Store request this cycle.
REQ-007 MemRead  input  1  Load request this cycle.
REQ-008 readdata  output  32  Load result, registered.
REQ-009 stall  output  1  Store not accepted this cycle; the core holds the request.
REQ-010 buf_count  output  3  Occupied store-buffer entries, 0..4.

Function
REQ-011 Storage SHALL be a 64 x 32-bit single-port RAM plus a 4-entry FIFO store buffer; each entry holds a 6-bit word index and 32-bit data.
REQ-012 stall SHALL be combinational: stall = MemWrite AND (buf_count == 4); a drain in the same cycle does not clear stall.
REQ-013 A store SHALL be accepted when MemWrite=1 and stall=0; at the next edge {ALUout[7:2], writedata} is written at the tail and the tail pointer advances.
REQ-014 A stall cycle SHALL leave the buffer contents and pointers unchanged.
REQ-015 Drain: when buf_count>0 and MemRead=0, the head entry SHALL be written to the RAM at the edge and the head pointer advances (one entry per cycle).
REQ-016 When MemRead=1, the RAM port SHALL serve the load, and no drain occurs that cycle.
REQ-017 Head and tail pointers SHALL be 2 bits wide and wrap from 3 to 0.
REQ-018 Accept and drain in the same cycle SHALL leave buf_count unchanged.
REQ-019 A load (MemRead=1, MemWrite=0) SHALL update readdata at the next edge, giving 1-cycle latency.
REQ-020 Load data SHALL be taken from the youngest valid buffer entry whose index matches ALUout[7:2]; if no entry matches, it SHALL be taken from RAM[ALUout[7:2]].
REQ-021 The forwarding compare SHALL use the buffer state before the edge; a store accepted in the same edge is not visible to that load.
REQ-022 MemRead=1 and MemWrite=1 together SHALL be treated as a store only; the load is ignored and readdata holds.
REQ-023 readdata SHALL hold its value in every cycle without an executed load.
REQ-024 Multiple buffer entries to the same index SHALL drain in FIFO order, so the last-accepted data wins in RAM.

Reset
REQ-025 On reset, the head and tail pointers, buf_count and readdata SHALL clear to 0, and stall SHALL follow REQ-012 with buf_count=0.
REQ-026 Reset SHALL NOT clear the RAM contents.
REQ-027 Reset asserted while the buffer is non-empty SHALL discard all pending stores; none of them reach the RAM.
REQ-028 Reset SHALL take priority over any same-cycle store, drain or load.

Verification
REQ-029 Store 0xDEADBEEF to ALUout=0x10, then idle 2 cycles, then load 0x10 -> buf_count goes 1 then 0, and readdata=0xDEADBEEF one cycle after the load.
REQ-030 Store 0x11111111 to 0x20 and then 0x22222222 to 0x20 with MemRead held high (no drain), then load 0x20 -> readdata=0x22222222 (youngest forwarded); after draining, RAM[8]=0x22222222.
REQ-031 Five back-to-back stores with MemRead=1 throughout (no drain) -> stall=1 on the 5th, buf_count=4; after MemRead drops, stall clears and the 5th store is accepted.
REQ-032 Load from 0x40 with a buffer holding only other indices -> readdata=RAM[16]; readdata holds across following idle cycles.
REQ-033 Fill 3 entries, then assert reset for 1 cycle -> buf_count=0, readdata=0; a subsequent load of those addresses returns the pre-store RAM values.
REQ-034 With the tail at 3, store and drain simultaneously for 6 cycles -> buf_count stays constant, the pointers wrap, and every stored value appears in RAM in order.
